// File: rtl/mult32_seq.sv
// rtl/mult32_seq.sv - sequential unsigned WIDTHxWIDTH shift-add multiplier; optional EARLY_TERM_EN
module mult32_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;

    // acc holds the partial product in the upper half and the unconsumed
    // multiplier bits in the lower half; both move right one place per step
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     mcand;
    logic [CW-1:0]        cnt;

    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   acc_shift;
    logic [2*WIDTH-1:0]   result;
    logic                 last_step;
    logic                 finish;
    logic                 load;

`ifdef EARLY_TERM_EN
    logic [CW-1:0]        rem;
    logic [WIDTH-1:0]     rem_mask;
    logic                 rem_zero;
`endif

    // start is honoured only when no operation is in flight
    assign load = start && ((state == S_IDLE) || (state == S_DONE));

    // one shift-add step; the carry lands in bit 2W-1 so nothing is lost
    always_comb begin
        sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        acc_shift = {sum, acc[WIDTH-1:1]};
        last_step = (cnt == CW'(WIDTH - 1));
    end

`ifdef EARLY_TERM_EN
    // stop once the multiplier bits still waiting to be consumed are all zero;
    // the skipped steps would only shift, so realign by that many places
    always_comb begin
        rem      = CW'(WIDTH - 1) - cnt;
        rem_mask = ~({WIDTH{1'b1}} << rem);
        rem_zero = ((acc_shift[WIDTH-1:0] & rem_mask) == {WIDTH{1'b0}});
        finish   = last_step || rem_zero;
        result   = acc_shift >> rem;
    end
`else
    // fixed-length run: always WIDTH steps, so latency never depends on data
    always_comb begin
        finish = last_step;
        result = acc_shift;
    end
`endif

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state decode; DONE can chain straight into a new RUN
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = start ? S_RUN : S_IDLE;
            S_RUN:   state_nxt = finish ? S_DONE : S_RUN;
            S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // status outputs decoded straight from the state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // datapath: operand capture, iteration, and result register updated only on DONE entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc   <= '0;
            mcand <= '0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (load) begin
            mcand <= A;
            acc   <= {{WIDTH{1'b0}}, B};
            cnt   <= '0;
        end else if (state == S_RUN) begin
            cnt <= cnt + CW'(1);
            if (finish) begin
                acc      <= result;
                {hi, lo} <= result;
            end else begin
                acc <= acc_shift;
            end
        end
    end

endmodule

// File: tb/tb_mult32_seq.sv
// tb/tb_mult32_seq.sv - directed self-checking bench for mult32_seq
module tb_mult32_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    mult32_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // drive one request; returns in cycle k+1 where k is the sampling edge
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit hold);
        start = 1'b1;
        A     = a;
        B     = b;
        step();
        if (!hold) begin
            start = 1'b0;
            A     = $urandom;
            B     = $urandom;
        end
    endtask

    // n = cycle offset from the sampling edge at which done is seen
    task automatic wait_done(output int n, output int nbusy, output bit held);
        logic [31:0] h0;
        logic [31:0] l0;
        h0    = hi;
        l0    = lo;
        n     = 1;
        nbusy = 0;
        held  = 1'b1;
        while (done !== 1'b1 && n < 100) begin
            if (busy === 1'b1) nbusy++;
            if (hi !== h0 || lo !== l0) held = 1'b0;
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        int nb;
        bit held;
        int pulses;

        rst_n = 1'b0;
        start = 1'b0;
        A     = '0;
        B     = '0;
        step();
        step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        rst_n = 1'b1;
        step();

        // 3 x 4: fixed latency and busy window
        issue(32'd3, 32'd4, 1'b0);
        wait_done(n, nb, held);
        check("t2_lat", n, 33);
        check("t2_busy_cycles", nb, 32);
        check("t2_hi", hi, 0);
        check("t2_lo", lo, 12);
        step();
        check("t2_done_pulse", done, 0);
        check("t2_lo_hold", lo, 12);

        // reset in the middle of a run aborts it
        issue(32'd5, 32'd7, 1'b0);
        step();
        step();
        step();
        rst_n = 1'b0;
        step();
        check("t1_busy", busy, 0);
        check("t1_done", done, 0);
        check("t1_hi", hi, 0);
        check("t1_lo", lo, 0);
        step();
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) pulses++;
            step();
        end
        check("t1_no_done", pulses, 0);
        check("t1_idle_busy", busy, 0);

        // full-scale operands
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done(n, nb, held);
        check("t3_lat", n, 33);
        check("t3_hi", hi, 32'hFFFF_FFFE);
        check("t3_lo", lo, 32'h0000_0001);
        step();

        // carry into hi, then back-to-back op accepted in the DONE cycle
        issue(32'h8000_0000, 32'd2, 1'b1);
        A = 32'd6;
        B = 32'd7;
        wait_done(n, nb, held);
        check("t4_lat", n, 33);
        check("t4_hi", hi, 1);
        check("t4_lo", lo, 0);
        step();
        start = 1'b0;
        A     = 32'hDEAD_BEEF;
        B     = 32'h1234_5678;
        check("t4_b2b_busy", busy, 1);
        check("t4_b2b_hi_run", hi, 1);
        check("t4_b2b_lo_run", lo, 0);
        wait_done(n, nb, held);
        check("t4_b2b_lat", n, 33);
        check("t4_b2b_held", held, 1);
        check("t4_b2b_hi", hi, 0);
        check("t4_b2b_lo", lo, 42);
        step();

        // start during RUN is ignored
        issue(32'd100, 32'd200, 1'b0);
        step();
        step();
        step();
        step();
        start = 1'b1;
        A     = 32'd9;
        B     = 32'd9;
        step();
        start = 1'b0;
        wait_done(n, nb, held);
        check("t5_lat", n + 5, 33);
        check("t5_hi", hi, 0);
        check("t5_lo", lo, 32'd20000);
        step();
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) pulses++;
            step();
        end
        check("t5_single_done", pulses, 0);
        check("t5_lo_hold", lo, 32'd20000);

        // zero and short multipliers: identical results, latency depends on build
        issue(32'd123, 32'd0, 1'b0);
        wait_done(n, nb, held);
`ifdef EARLY_TERM_EN
        check("t6_b0_lat", n, 2);
`else
        check("t6_b0_lat", n, 33);
`endif
        check("t6_b0_hi", hi, 0);
        check("t6_b0_lo", lo, 0);
        step();

        issue(32'd7, 32'd1, 1'b0);
        wait_done(n, nb, held);
`ifdef EARLY_TERM_EN
        check("t6_b1_lat", n, 2);
`else
        check("t6_b1_lat", n, 33);
`endif
        check("t6_b1_hi", hi, 0);
        check("t6_b1_lo", lo, 7);
        step();

        issue(32'd5, 32'h0000_0100, 1'b0);
        wait_done(n, nb, held);
`ifdef EARLY_TERM_EN
        check("t6_b256_lat", n, 10);
`else
        check("t6_b256_lat", n, 33);
`endif
        check("t6_b256_hi", hi, 0);
        check("t6_b256_lo", lo, 32'h0000_0500);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
